mayo_axil_slave_regs: RTL and testbench

- AXI4-Lite slave (responder) register bank for the MAYO/SHAKE IP.
- Terminates the AXI4-Lite master traffic issued by the block-design master VIP.
- Exposes NUM_REGS 32-bit read/write registers to the accelerator core, plus one-cycle per-register write pulses.
- Independent write and read channel FSMs; one outstanding transaction per direction.

---
 rtl/mayo_axil_slave_regs_pkg.sv | 37 +++
 rtl/mayo_axil_slave_regs_if.sv | 52 +++++
 rtl/mayo_axil_slave_regs_regbank.sv | 62 ++++++
 rtl/mayo_axil_slave_regs.sv | 189 ++++++++++++++++++
 tb/tb_mayo_axil_slave_regs.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mayo_axil_slave_regs_pkg.sv
// Shared definitions for the MAYO/SHAKE AXI4-Lite register slave:
// response codes, channel FSM state types and the byte-strobe merge helper.
`timescale 1ns/1ps
package mayo_axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mayo_axil_slave_regs_if.sv
// AXI4-Lite bus bundle between the block-design master and the register slave.
`timescale 1ns/1ps
interface mayo_axil_slave_regs_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/mayo_axil_slave_regs_regbank.sv
// Register storage for the AXI4-Lite slave: NUM_REGS 32-bit words with
// byte-strobe writes, a one-cycle write pulse per word and a combinational
// read mux (out-of-range index reads as zero).
`timescale 1ns/1ps
module mayo_axil_regbank
    import mayo_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_WIDTH-3:0]    wr_idx,
    input  logic [31:0]              wr_data,
    input  logic [3:0]               wr_strb,
    input  logic [ADDR_WIDTH-3:0]    rd_idx,
    output logic [31:0]              rd_data,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);
    localparam int IDX_W = ADDR_WIDTH - 2;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_word
            logic        wr_hit;
            logic [31:0] word_reg;
            logic        pulse_reg;

            // An out-of-range index never matches any word, so it is dropped here.
            assign wr_hit = wr_en && (wr_idx == IDX_W'(gi));

            // Word storage with per-lane merge; pulse marks the cycle after commit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_reg  <= 32'h0;
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= wr_hit;
                    if (wr_hit) begin
                        word_reg <= strb_merge(word_reg, wr_data, wr_strb);
                    end
                end
            end

            assign reg_q[32*gi +: 32] = word_reg;
            assign reg_wr_pulse[gi]   = pulse_reg;
        end
    endgenerate

    // Read mux sees the pre-write contents when a write commits on the same edge.
    always_comb begin
        rd_data = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = reg_q[32*i +: 32];
            end
        end
    end

endmodule

// File: rtl/mayo_axil_slave_regs.sv
// AXI4-Lite slave register bank for the MAYO/SHAKE IP.
// Independent write (AW/W/B) and read (AR/R) channel FSMs, one outstanding
// transaction per direction. Optional macro MAYO_AXIL_SLVERR_EN makes
// out-of-range accesses answer SLVERR instead of OKAY.
`timescale 1ns/1ps
module mayo_axil_slave_regs
    import mayo_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    mayo_axil_slave_regs_if.slave   s_axi,
    output logic [NUM_REGS*32-1:0]  reg_q,
    output logic [NUM_REGS-1:0]     reg_wr_pulse
);
    localparam int IDX_W = ADDR_WIDTH - 2;

    wr_state_t wr_state_reg, wr_state_next;
    rd_state_t rd_state_reg, rd_state_next;

    // Holds the READY outputs low until the first edge after reset release.
    logic ready_en_reg;

    logic [IDX_W-1:0]      awidx_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [3:0]            wstrb_reg;
    logic [1:0]            bresp_reg;
    logic [31:0]           rdata_reg;
    logic [1:0]            rresp_reg;

    logic aw_ready, w_ready, ar_ready;
    logic aw_hs, w_hs, ar_hs;

    logic             commit_en;
    logic [IDX_W-1:0] commit_idx;
    logic [31:0]      commit_data;
    logic [3:0]       commit_strb;
    logic [1:0]       commit_resp;

    logic [IDX_W-1:0] ar_idx;
    logic [31:0]      rd_data;
    logic [1:0]       rd_resp;

    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    assign aw_ready = ready_en_reg && ((wr_state_reg == W_IDLE) || (wr_state_reg == W_DATA));
    assign w_ready  = ready_en_reg && ((wr_state_reg == W_IDLE) || (wr_state_reg == W_ADDR));
    assign ar_ready = ready_en_reg && (rd_state_reg == R_IDLE);

    assign aw_hs = s_axi.S_AXI_AWVALID && aw_ready;
    assign w_hs  = s_axi.S_AXI_WVALID  && w_ready;
    assign ar_hs = s_axi.S_AXI_ARVALID && ar_ready;

    assign ar_idx = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];

    assign s_axi.S_AXI_AWREADY = aw_ready;
    assign s_axi.S_AXI_WREADY  = w_ready;
    assign s_axi.S_AXI_BVALID  = (wr_state_reg == W_RESP);
    assign s_axi.S_AXI_BRESP   = bresp_reg;
    assign s_axi.S_AXI_ARREADY = ar_ready;
    assign s_axi.S_AXI_RVALID  = (rd_state_reg == R_DATA);
    assign s_axi.S_AXI_RDATA   = rdata_reg;
    assign s_axi.S_AXI_RRESP   = rresp_reg;

`ifdef MAYO_AXIL_SLVERR_EN
    assign commit_resp = (int'(commit_idx) < NUM_REGS) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    assign rd_resp     = (int'(ar_idx) < NUM_REGS)     ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
`else
    assign commit_resp = AXI_RESP_OKAY;
    assign rd_resp     = AXI_RESP_OKAY;
`endif

    // Write channel next state; the commit selects live or latched AW/W fields.
    always_comb begin
        wr_state_next = wr_state_reg;
        commit_en     = 1'b0;
        commit_idx    = awidx_reg;
        commit_data   = wdata_reg[31:0];
        commit_strb   = wstrb_reg;
        case (wr_state_reg)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_state_next = W_RESP;
                    commit_en     = 1'b1;
                    commit_idx    = s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
                    commit_data   = s_axi.S_AXI_WDATA[31:0];
                    commit_strb   = s_axi.S_AXI_WSTRB;
                end else if (aw_hs) begin
                    wr_state_next = W_ADDR;
                end else if (w_hs) begin
                    wr_state_next = W_DATA;
                end
            end
            W_ADDR: begin
                if (w_hs) begin
                    wr_state_next = W_RESP;
                    commit_en     = 1'b1;
                    commit_data   = s_axi.S_AXI_WDATA[31:0];
                    commit_strb   = s_axi.S_AXI_WSTRB;
                end
            end
            W_DATA: begin
                if (aw_hs) begin
                    wr_state_next = W_RESP;
                    commit_en     = 1'b1;
                    commit_idx    = s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    // Write channel state, half-transaction latches and response code.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_reg <= W_IDLE;
            ready_en_reg <= 1'b0;
            awidx_reg    <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            bresp_reg    <= AXI_RESP_OKAY;
        end else begin
            wr_state_reg <= wr_state_next;
            ready_en_reg <= 1'b1;
            if (aw_hs) begin
                awidx_reg <= s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                wdata_reg <= s_axi.S_AXI_WDATA;
                wstrb_reg <= s_axi.S_AXI_WSTRB;
            end
            if (commit_en) begin
                bresp_reg <= commit_resp;
            end
        end
    end

    // Read channel next state.
    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            R_IDLE:  if (ar_hs) rd_state_next = R_DATA;
            R_DATA:  if (s_axi.S_AXI_RREADY) rd_state_next = R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Read channel state; data and response are captured at the AR handshake.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state_reg <= R_IDLE;
            rdata_reg    <= 32'h0;
            rresp_reg    <= AXI_RESP_OKAY;
        end else begin
            rd_state_reg <= rd_state_next;
            if (ar_hs) begin
                rdata_reg <= rd_data;
                rresp_reg <= rd_resp;
            end
        end
    end

    mayo_axil_regbank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regbank (
        .clk          (ACLK),
        .rst          (ARESET),
        .wr_en        (commit_en),
        .wr_idx       (commit_idx),
        .wr_data      (commit_data),
        .wr_strb      (commit_strb),
        .rd_idx       (ar_idx),
        .rd_data      (rd_data),
        .reg_q        (reg_q),
        .reg_wr_pulse (reg_wr_pulse)
    );

endmodule

// File: tb/tb_mayo_axil_slave_regs.sv
// Directed self-checking bench for mayo_axil_slave_regs (default 4 registers,
// 5-bit addresses). Expected response for out-of-range accesses follows
// MAYO_AXIL_SLVERR_EN.
`timescale 1ns/1ps
module tb_mayo_axil_slave_regs;

    localparam int AW = 5;
    localparam int NR = 4;
`ifdef MAYO_AXIL_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic [NR*32-1:0] reg_q;
    logic [NR-1:0]    reg_wr_pulse;

    int total = 0;
    int bad   = 0;
    logic [127:0] exp_q;

    mayo_axil_slave_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    mayo_axil_slave_regs #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .DATA_WIDTH(32)) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .s_axi        (bus.slave),
        .reg_q        (reg_q),
        .reg_wr_pulse (reg_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Wait (bounded) until AWREADY and WREADY are both high.
    task automatic wait_aw_w_ready(input string tag);
        int n = 0;
        while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready_wait"}, {127'b0, (n < 20)}, 128'd1);
    endtask

    // AW+W in one cycle, checks first BVALID cycle, then accepts B.
    task automatic write_check(input logic [AW-1:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [NR-1:0] exp_pulse,
                               input logic [1:0] exp_resp, input string tag);
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_WVALID  = 1'b1;
        wait_aw_w_ready(tag);
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        check({tag, "_bvalid"}, {127'b0, bus.S_AXI_BVALID}, 128'd1);
        check({tag, "_bresp"},  {126'b0, bus.S_AXI_BRESP}, {126'b0, exp_resp});
        check({tag, "_pulse"},  {124'b0, reg_wr_pulse}, {124'b0, exp_pulse});
        $display("wr addr=0x%02h data=0x%08h strb=%b bresp=%0d pulse=%b",
                 addr, data, strb, bus.S_AXI_BRESP, reg_wr_pulse);
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        check({tag, "_bdone"},  {127'b0, bus.S_AXI_BVALID}, 128'd0);
        check({tag, "_pulse_off"}, {124'b0, reg_wr_pulse}, 128'd0);
    endtask

    task automatic read_check(input logic [AW-1:0] addr, input logic [31:0] exp_data,
                              input logic [1:0] exp_resp, input string tag);
        int n = 0;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        while (!bus.S_AXI_ARREADY && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_arready_wait"}, {127'b0, (n < 20)}, 128'd1);
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        check({tag, "_rvalid"}, {127'b0, bus.S_AXI_RVALID}, 128'd1);
        check({tag, "_rdata"},  {96'b0, bus.S_AXI_RDATA}, {96'b0, exp_data});
        check({tag, "_rresp"},  {126'b0, bus.S_AXI_RRESP}, {126'b0, exp_resp});
        $display("rd addr=0x%02h data=0x%08h rresp=%0d", addr, bus.S_AXI_RDATA, bus.S_AXI_RRESP);
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
        check({tag, "_rdone"}, {127'b0, bus.S_AXI_RVALID}, 128'd0);
    endtask

    initial begin
        bus.S_AXI_AWADDR  = '0;
        bus.S_AXI_AWPROT  = 3'b000;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = 32'h0;
        bus.S_AXI_WSTRB   = 4'h0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = '0;
        bus.S_AXI_ARPROT  = 3'b000;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;
        exp_q = 128'h0;

        // Reset state
        repeat (3) tick();
        check("rst_awready", {127'b0, bus.S_AXI_AWREADY}, 128'd0);
        check("rst_wready",  {127'b0, bus.S_AXI_WREADY},  128'd0);
        check("rst_arready", {127'b0, bus.S_AXI_ARREADY}, 128'd0);
        check("rst_bvalid",  {127'b0, bus.S_AXI_BVALID},  128'd0);
        check("rst_rvalid",  {127'b0, bus.S_AXI_RVALID},  128'd0);
        check("rst_rdata",   {96'b0, bus.S_AXI_RDATA},    128'd0);
        check("rst_resp",    {124'b0, bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 128'd0);
        check("rst_regs",    reg_q, 128'd0);
        check("rst_pulse",   {124'b0, reg_wr_pulse}, 128'd0);
        ARESET = 1'b0;
        #1;
        check("rel_awready_low", {127'b0, bus.S_AXI_AWREADY}, 128'd0);
        tick();
        check("rel_ready_up", {125'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 128'd7);

        // Sequential writes then reads
        write_check(5'h00, 32'h1, 4'hF, 4'b0001, 2'b00, "seq_w0");
        write_check(5'h04, 32'h2, 4'hF, 4'b0010, 2'b00, "seq_w1");
        write_check(5'h08, 32'h3, 4'hF, 4'b0100, 2'b00, "seq_w2");
        write_check(5'h0C, 32'h4, 4'hF, 4'b1000, 2'b00, "seq_w3");
        exp_q = {32'h4, 32'h3, 32'h2, 32'h1};
        check("seq_regs", reg_q, exp_q);
        read_check(5'h00, 32'h1, 2'b00, "seq_r0");
        read_check(5'h04, 32'h2, 2'b00, "seq_r1");
        read_check(5'h08, 32'h3, 2'b00, "seq_r2");
        read_check(5'h0C, 32'h4, 2'b00, "seq_r3");

        // AW three cycles ahead of W
        bus.S_AXI_AWADDR  = 5'h08;
        bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        check("awfirst_ready", {126'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 128'd1);
        check("awfirst_nob",   {127'b0, bus.S_AXI_BVALID}, 128'd0);
        tick();
        tick();
        bus.S_AXI_WDATA  = 32'hDEADBEEF;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        exp_q[95:64] = 32'hDEADBEEF;
        check("awfirst_bvalid", {127'b0, bus.S_AXI_BVALID}, 128'd1);
        check("awfirst_pulse",  {124'b0, reg_wr_pulse}, 128'd4);
        check("awfirst_regs",   reg_q, exp_q);
        $display("wr addr=0x08 data=0xdeadbeef aw-first bresp=%0d", bus.S_AXI_BRESP);
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;

        // W three cycles ahead of AW
        bus.S_AXI_WDATA  = 32'hCAFEF00D;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_WDATA  = 32'h0;
        check("wfirst_ready", {126'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 128'd2);
        tick();
        tick();
        check("wfirst_hold", reg_q, exp_q);
        bus.S_AXI_AWADDR  = 5'h08;
        bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        exp_q[95:64] = 32'hCAFEF00D;
        check("wfirst_bvalid", {127'b0, bus.S_AXI_BVALID}, 128'd1);
        check("wfirst_pulse",  {124'b0, reg_wr_pulse}, 128'd4);
        check("wfirst_regs",   reg_q, exp_q);
        $display("wr addr=0x08 data=0xcafef00d w-first bresp=%0d", bus.S_AXI_BRESP);
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;

        // Byte-strobe merge
        write_check(5'h04, 32'h11223344, 4'hF, 4'b0010, 2'b00, "strb_init");
        write_check(5'h04, 32'hAABBCCDD, 4'b0101, 4'b0010, 2'b00, "strb_part");
        exp_q[63:32] = 32'h11BB33DD;
        check("strb_regs", reg_q, exp_q);

        // Zero strobe still commits and pulses without changing data
        write_check(5'h04, 32'hFFFFFFFF, 4'b0000, 4'b0010, 2'b00, "strb_zero");
        check("strb_zero_regs", reg_q, exp_q);

        // Simultaneous read and write of reg 3: read sees the old value
        bus.S_AXI_AWADDR  = 5'h0C;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = 32'h99;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_ARADDR  = 5'h0C;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_ARVALID = 1'b0;
        exp_q[127:96] = 32'h99;
        check("rw_same_rvalid", {126'b0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 128'd3);
        check("rw_same_rdata",  {96'b0, bus.S_AXI_RDATA}, 128'h4);
        check("rw_same_regs",   reg_q, exp_q);
        $display("wr+rd addr=0x0c wdata=0x99 rdata=0x%08h", bus.S_AXI_RDATA);
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_RREADY = 1'b0;

        // B backpressure: response held for five cycles
        bus.S_AXI_AWADDR  = 5'h00;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = 32'hA5A5A5A5;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_WVALID  = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        exp_q[31:0] = 32'hA5A5A5A5;
        for (int c = 0; c < 5; c++) begin
            check("bp_b_hold", {124'b0, bus.S_AXI_BVALID, bus.S_AXI_BRESP, 1'b0}, 128'd8);
            check("bp_b_rdy",  {126'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 128'd0);
            tick();
        end
        $display("wr addr=0x00 data=0xa5a5a5a5 held bresp=%0d", bus.S_AXI_BRESP);
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        check("bp_b_done", {126'b0, bus.S_AXI_AWREADY, bus.S_AXI_BVALID}, 128'd2);

        // R backpressure: data held for four cycles
        bus.S_AXI_ARADDR  = 5'h00;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("bp_r_hold", {93'b0, bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA},
                  {93'b0, 1'b1, 2'b00, 32'hA5A5A5A5});
            check("bp_r_arrdy", {127'b0, bus.S_AXI_ARREADY}, 128'd0);
            tick();
        end
        $display("rd addr=0x00 data=0x%08h held", bus.S_AXI_RDATA);
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
        check("bp_r_done", {127'b0, bus.S_AXI_RVALID}, 128'd0);

        // Out-of-range index 5
        write_check(5'h14, 32'h55, 4'hF, 4'b0000, OOR_RESP, "oor_w");
        check("oor_regs", reg_q, exp_q);
        read_check(5'h14, 32'h0, OOR_RESP, "oor_r");

        // Reset while in W_ADDR
        bus.S_AXI_AWADDR  = 5'h04;
        bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        check("mid_waddr", {126'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 128'd1);
        ARESET = 1'b1;
        #1;
        check("mid_rst_rdy", {125'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 128'd0);
        check("mid_rst_b",   {127'b0, bus.S_AXI_BVALID}, 128'd0);
        check("mid_rst_regs", reg_q, 128'd0);
        tick();
        ARESET = 1'b0;
        tick();
        exp_q = 128'h0;
        write_check(5'h04, 32'h7, 4'hF, 4'b0010, 2'b00, "post_rst_w");
        exp_q[63:32] = 32'h7;
        check("post_rst_regs", reg_q, exp_q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
